bit_align_lock: RTL
===================

Name: bit_align_lock

Overview:
- Alignment controller that sits directly downstream of the 4-bit bit aligner on each TURFIO input lane.
- Consumes the aligner's nibble output and valid strobe during link training, and compares each nibble with a known training nibble.
- Drives the aligner's slip and reset inputs until the lane is locked, then monitors the lock.
- Reports lock, failure and error status to the lane control registers.

Parameters:
TRAIN_NIBBLE, 4'b0110, expected aligned training nibble; its 4 rotations must be distinct.
MATCH_COUNT, 64, consecutive matching valid nibbles required to declare lock (1..65535).
SETTLE_BEATS, 2, valid nibbles discarded after every slip or aligner reset (1..15).
MAX_SWEEPS, 4, full 4-slip sweeps tried before declaring failure (1..15).
ERR_THRESH, 8, consecutive mismatches while locked that drop lock (1..255).

Ports:
clk  in  1  lane clock, same clock as the aligner
rst_n  in  1  asynchronous active-low reset
enable  in  1  training/monitor enable; low forces IDLE
restart  in  1  single-cycle pulse; restarts training from ALIGN_RST
din  in  4  aligned nibble from the aligner output
ce_din  in  1  aligner output-valid strobe
slip  out  1  single-cycle slip request to the aligner
align_rst  out  1  synchronous active-high reset to the aligner
locked  out  1  lane locked
fail  out  1  training exhausted without lock; sticky until restart or enable low
slip_ptr  out  2  shadow of the aligner's slip pointer (slips issued mod 4)
err_count  out  16  mismatches counted while locked, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0; all internal counters 0.
- States: IDLE, ALIGN_RST, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE:
  - enable 1 -> ALIGN_RST.
  - enable 0 in any state -> IDLE on the next clk. locked and fail clear; err_count holds.
- ALIGN_RST:
  - align_rst = 1 for exactly one clk.
  - Clears slip_ptr, the sweep counter and the match counter.
  - -> SETTLE.
- SETTLE:
  - Counts ce_din beats, ignoring din.
  - After SETTLE_BEATS beats -> CHECK. Cycles with ce_din low do not count.
- CHECK:
  - On each ce_din with din == TRAIN_NIBBLE: match counter +1. Reaching MATCH_COUNT -> LOCKED.
  - On ce_din with a mismatch: clear the match counter -> SLIP.
- SLIP:
  - slip = 1 for exactly one clk; slip_ptr increments mod 4.
  - If slip_ptr wraps 3->0, the sweep counter +1. If it then equals MAX_SWEEPS -> FAIL; otherwise -> SETTLE.
  - slip is never asserted on two consecutive clks. At least SETTLE_BEATS valid beats separate slips.
- LOCKED:
  - locked = 1; slip_ptr frozen.
  - On each ce_din mismatch: err_count +1 (saturating) and the consecutive-error counter +1. On a match the consecutive-error counter clears.
  - Consecutive-error counter reaching ERR_THRESH -> locked = 0, clear match counter -> CHECK. No aligner reset; slipping resumes from the current slip_ptr.
- FAIL:
  - fail = 1; no slips issued.
  - Stays until restart or enable low.
- restart:
  - In any state other than IDLE -> ALIGN_RST on the next clk.
  - Clears locked, fail and err_count.
  - restart takes priority over every other transition in the same cycle. Ignored in IDLE.
- Timing:
  - Registered outputs only. locked rises one clk after the ce_din beat that completes MATCH_COUNT.
  - slip is issued the clk after the mismatching beat.
- Simultaneous events:
  - ce_din in the same clk as slip or align_rst: that beat is not evaluated.
  - restart with ce_din: restart wins.
- Counters are wide enough for parameter maxima. Match counter is 16 bits; the consecutive-error counter never exceeds ERR_THRESH.

Test Plan:
- Aligner model with initial rotation 0, lane sending 4'b0110 on every valid beat, ce_din every 4th clk -> no slips; locked = 1 after 2 + 64 valid beats; slip_ptr = 0.
- Lane needing 3 slips -> exactly 3 single-clk slip pulses, each separated by 2 discarded beats plus 1 mismatch; locked with slip_ptr = 3.
- Lane sending 4'b1010 constantly, MAX_SWEEPS = 4 -> 16 slips, then fail = 1; no further slips over 1000 clks; restart -> align_rst pulse, fail = 0, retraining begins.
- Locked, then inject 7 consecutive mismatches and 1 match, repeated -> stays locked, err_count = 7 per burst; inject 8 consecutive mismatches -> locked drops, slip issued, relock with slip_ptr unchanged mod rotation.
- Assert rst_n low asynchronously mid-SETTLE and mid-SLIP -> all outputs 0 immediately; enable low mid-CHECK -> IDLE next clk, no slip.
- restart in the same clk as the 64th matching beat -> locked stays 0; align_rst pulses; err_count = 0.

Source files
------------

// File: rtl/bit_align_lock.sv
// Lane alignment controller: steers a 4-bit bit aligner with slip/reset until the
// training nibble is seen MATCH_COUNT times in a row, then monitors the lock.
module bit_align_lock #(
  parameter logic [3:0]  TRAIN_NIBBLE = 4'b0110,
  parameter int unsigned MATCH_COUNT  = 64,
  parameter int unsigned SETTLE_BEATS = 2,
  parameter int unsigned MAX_SWEEPS   = 4,
  parameter int unsigned ERR_THRESH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        restart,
  input  logic [3:0]  din,
  input  logic        ce_din,
  output logic        slip,
  output logic        align_rst,
  output logic        locked,
  output logic        fail,
  output logic [1:0]  slip_ptr,
  output logic [15:0] err_count
);

  // Handshake: ce_din qualifies din for one clk; there is no back-pressure.
  // slip and align_rst are one-clk pulses that the aligner acts on immediately.

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN_RST,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_BEATS - 1);
  localparam logic [15:0] MATCH_LAST  = 16'(MATCH_COUNT - 1);
  localparam logic [3:0]  SWEEP_MAX   = 4'(MAX_SWEEPS);
  localparam logic [7:0]  ERR_LAST    = 8'(ERR_THRESH - 1);

  state_e      state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] match_q, match_d;
  logic [3:0]  sweep_q, sweep_d;
  logic [7:0]  cerr_q, cerr_d;
  logic [1:0]  slip_ptr_q, slip_ptr_d;
  logic [15:0] err_count_q, err_count_d;
  logic        slip_q, slip_d;
  logic        align_rst_q, align_rst_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;
  logic        is_match;

  assign is_match = (din == TRAIN_NIBBLE);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    match_d     = match_q;
    sweep_d     = sweep_q;
    cerr_d      = cerr_q;
    slip_ptr_d  = slip_ptr_q;
    err_count_d = err_count_q;

    // enable low is a hard force to IDLE; restart only acts while enabled.
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (restart && (state_q != ST_IDLE)) begin
      state_d     = ST_ALIGN_RST;
      err_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_ALIGN_RST;
        ST_ALIGN_RST: state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (ce_din) begin
            if (settle_q == SETTLE_LAST) begin
              settle_d = '0;
              state_d  = ST_CHECK;
            end else begin
              settle_d = settle_q + 4'd1;
            end
          end
        end
        ST_CHECK: begin
          if (ce_din) begin
            if (is_match) begin
              if (match_q == MATCH_LAST) begin
                match_d = '0;
                cerr_d  = '0;
                state_d = ST_LOCKED;
              end else begin
                match_d = match_q + 16'd1;
              end
            end else begin
              match_d    = '0;
              slip_ptr_d = slip_ptr_q + 2'd1;
              if (slip_ptr_q == 2'd3) sweep_d = sweep_q + 4'd1;
              state_d    = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          if (sweep_q == SWEEP_MAX) begin
            state_d = ST_FAIL;
          end else begin
            settle_d = '0;
            state_d  = ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          if (ce_din) begin
            if (is_match) begin
              cerr_d = '0;
            end else begin
              if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
              if (cerr_q == ERR_LAST) begin
                cerr_d  = '0;
                match_d = '0;
                state_d = ST_CHECK;
              end else begin
                cerr_d = cerr_q + 8'd1;
              end
            end
          end
        end
        ST_FAIL:  state_d = ST_FAIL;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Entering ALIGN_RST restarts the whole search from rotation 0.
    if (state_d == ST_ALIGN_RST) begin
      slip_ptr_d = '0;
      sweep_d    = '0;
      match_d    = '0;
      settle_d   = '0;
      cerr_d     = '0;
    end

    slip_d      = (state_d == ST_SLIP);
    align_rst_d = (state_d == ST_ALIGN_RST);
    locked_d    = (state_d == ST_LOCKED);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      match_q     <= '0;
      sweep_q     <= '0;
      cerr_q      <= '0;
      slip_ptr_q  <= '0;
      err_count_q <= '0;
      slip_q      <= 1'b0;
      align_rst_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      match_q     <= match_d;
      sweep_q     <= sweep_d;
      cerr_q      <= cerr_d;
      slip_ptr_q  <= slip_ptr_d;
      err_count_q <= err_count_d;
      slip_q      <= slip_d;
      align_rst_q <= align_rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign slip      = slip_q;
  assign align_rst = align_rst_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign slip_ptr  = slip_ptr_q;
  assign err_count = err_count_q;

endmodule
